// File: rtl/seg_word_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_word_reader_pkg
//  Description : Shared character codes, 7-segment patterns (active-low,
//                bit 0 = segment a) and the reference word for the segment
//                word reader and display-side blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_word_reader_pkg;

  // Character codes produced by the segment decoder
  typedef enum logic [2:0] {
    CH_SPACE = 3'd0,
    CH_A     = 3'd1,
    CH_U     = 3'd2,
    CH_T     = 3'd3,
    CH_O     = 3'd4,
    CH_BAD   = 3'd7
  } char_code_e;

  // Segment patterns, written in [0:6] order (leftmost bit is segment a)
  localparam logic [0:6] SEG_SPACE = 7'b1111111;
  localparam logic [0:6] SEG_A     = 7'b0000010;
  localparam logic [0:6] SEG_U     = 7'b1100011;
  localparam logic [0:6] SEG_T     = 7'b1110000;
  localparam logic [0:6] SEG_O     = 7'b1100010;

  localparam int         WORD_LEN    = 6;
  localparam logic [2:0] POS_UNKNOWN = 3'b111;

  // Reader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_MATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Reference word W[0..5] = O,T,U,A,SPACE,SPACE
  function automatic char_code_e word_char(input int unsigned k);
    case (k)
      0:       return CH_O;
      1:       return CH_T;
      2:       return CH_U;
      3:       return CH_A;
      default: return CH_SPACE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_char_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_char_decode
//  Description : Combinational 7-segment pattern to character code decode.
//                Any pattern outside the known alphabet decodes to CH_BAD.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_char_decode
  import seg_word_reader_pkg::*;
(
  input  logic [0:6]  seg,
  output char_code_e  code
);

  // Exact-match lookup; unknown patterns are flagged as BAD
  always_comb begin
    code = CH_BAD;
    case (seg)
      SEG_SPACE: code = CH_SPACE;
      SEG_A:     code = CH_A;
      SEG_U:     code = CH_U;
      SEG_T:     code = CH_T;
      SEG_O:     code = CH_O;
      default:   code = CH_BAD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seg_word_reader
//  Description : Samples six 7-segment buses one digit per clock, then finds
//                which rotation of the word "OTUA  " they display.
//                Optional macro SEG_WORD_READER_AUTOSCAN_EN: passes run
//                back-to-back from reset release and start is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_word_reader
  import seg_word_reader_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [0:6]  HEX0,
  input  logic [0:6]  HEX1,
  input  logic [0:6]  HEX2,
  input  logic [0:6]  HEX3,
  input  logic [0:6]  HEX4,
  input  logic [0:6]  HEX5,
  input  logic        start,
  output logic        busy,
  output logic        valid,
  output logic [2:0]  position,
  output logic        error
);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  char_code_e        codes_q [WORD_LEN];
  char_code_e        codes_d [WORD_LEN];
  logic [2:0]        position_q, position_d;
  logic              error_q, error_d;
  logic              valid_q, valid_d;

  logic [0:6]        seg_sel;
  char_code_e        seg_code;
  logic [WORD_LEN-1:0] rot_hit;
  logic              match_any;
  logic [2:0]        match_pos;

`ifdef SEG_WORD_READER_AUTOSCAN_EN
  logic unused_start;
  assign unused_start = start;
`endif

  // Route the digit addressed by the scan index to the single decoder
  always_comb begin
    seg_sel = SEG_SPACE;
    case (idx_q)
      3'd0:    seg_sel = HEX0;
      3'd1:    seg_sel = HEX1;
      3'd2:    seg_sel = HEX2;
      3'd3:    seg_sel = HEX3;
      3'd4:    seg_sel = HEX4;
      3'd5:    seg_sel = HEX5;
      default: seg_sel = SEG_SPACE;
    endcase
  end

  seg7_char_decode u_decode (
    .seg  (seg_sel),
    .code (seg_code)
  );

  // All six rotations compared in parallel against the stored codes
  for (genvar p = 0; p < WORD_LEN; p++) begin : g_rot
    logic [WORD_LEN-1:0] digit_ok;
    for (genvar k = 0; k < WORD_LEN; k++) begin : g_digit
      assign digit_ok[k] = (codes_q[(p + k) % WORD_LEN] == word_char(k));
    end
    assign rot_hit[p] = &digit_ok;
  end

  // Lowest matching rotation wins; the word is asymmetric so at most one hits
  always_comb begin
    match_any = 1'b0;
    match_pos = POS_UNKNOWN;
    for (int p = 0; p < WORD_LEN; p++) begin
      if (rot_hit[p] && !match_any) begin
        match_any = 1'b1;
        match_pos = 3'(p);
      end
    end
  end

  // Next-state and datapath updates for the scan/match sequence
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    codes_d    = codes_q;
    position_d = position_q;
    error_d    = error_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
`ifdef SEG_WORD_READER_AUTOSCAN_EN
        state_d = ST_SCAN;
        idx_d   = 3'd0;
`else
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = 3'd0;
        end
`endif
      end
      ST_SCAN: begin
        codes_d[idx_q] = seg_code;
        if (idx_q == 3'(WORD_LEN - 1)) begin
          state_d = ST_MATCH;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_MATCH: begin
        // Result lands in the output registers together with the valid pulse
        position_d = match_any ? match_pos : POS_UNKNOWN;
        error_d    = !match_any;
        valid_d    = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        idx_d = 3'd0;
`ifdef SEG_WORD_READER_AUTOSCAN_EN
        state_d = ST_SCAN;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with asynchronous active-low reset
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      for (int i = 0; i < WORD_LEN; i++) codes_q[i] <= CH_SPACE;
      position_q <= POS_UNKNOWN;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      codes_q    <= codes_d;
      position_q <= position_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign valid    = valid_q;
  assign position = position_q;
  assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_word_reader
//  Description : Self-checking bench for seg_word_reader. The reference model
//                decodes patterns to characters and compares string rotations
//                of "OTUA  " directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_word_reader;

  localparam logic [0:6] P_SP = 7'b1111111;
  localparam logic [0:6] P_A  = 7'b0000010;
  localparam logic [0:6] P_U  = 7'b1100011;
  localparam logic [0:6] P_T  = 7'b1110000;
  localparam logic [0:6] P_O  = 7'b1100010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [0:6] hex [6];
  logic       busy, valid, error;
  logic [2:0] position;

  int         total = 0;
  int         bad   = 0;
  logic [2:0] prev_pos;
  logic       prev_err;
  string      word = "OTUA  ";

  always #5 clk = ~clk;

  seg_word_reader dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .HEX0     (hex[0]),
    .HEX1     (hex[1]),
    .HEX2     (hex[2]),
    .HEX3     (hex[3]),
    .HEX4     (hex[4]),
    .HEX5     (hex[5]),
    .start    (start),
    .busy     (busy),
    .valid    (valid),
    .position (position),
    .error    (error)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic byte seg2ch(input logic [0:6] s);
    case (s)
      P_SP:    return " ";
      P_A:     return "A";
      P_U:     return "U";
      P_T:     return "T";
      P_O:     return "O";
      default: return "?";
    endcase
  endfunction

  function automatic logic [0:6] ch2seg(input byte c);
    case (c)
      "A":     return P_A;
      "U":     return P_U;
      "T":     return P_T;
      "O":     return P_O;
      default: return P_SP;
    endcase
  endfunction

  // Model: which rotation p makes the sampled string read "OTUA  "
  task automatic ref_result(input byte s [6], output logic [2:0] pos, output logic err);
    pos = 3'b111;
    err = 1'b1;
    for (int p = 0; p < 6; p++) begin
      bit ok = 1'b1;
      for (int k = 0; k < 6; k++) if (s[(p + k) % 6] != word[k]) ok = 1'b0;
      if (ok) begin
        pos = 3'(p);
        err = 1'b0;
      end
    end
  endtask

  task automatic set_rot(input int p);
    for (int k = 0; k < 6; k++) hex[(p + k) % 6] = ch2seg(word[k]);
  endtask

`ifndef SEG_WORD_READER_AUTOSCAN_EN
  // One full pass: accept start, follow 8 busy cycles, then idle.
  // chaos rewrites already-sampled digits; poke pulses start mid-pass.
  task automatic run_pass(input bit chaos, input bit poke);
    byte        smp [6];
    logic [2:0] ep;
    logic       ee;
    ep = 3'b111;
    ee = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_at_accept", busy, 1'b1);
    chk("valid_at_accept", valid, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      if (n <= 6) smp[n-1] = seg2ch(hex[n-1]);
      if (n == 6) ref_result(smp, ep, ee);
      @(posedge clk); #1;
      start = (poke && n == 3);
      if (chaos && n <= 6)
        for (int j = 0; j < n; j++) hex[j] = 7'($urandom);
      chk("busy_in_pass", busy, 1'b1);
      if (n < 7) begin
        chk("valid_early", valid, 1'b0);
        chk("pos_hold", position, prev_pos);
      end else begin
        chk("valid_pulse", valid, 1'b1);
        chk("position", position, ep);
        chk("error", error, ee);
      end
    end
    @(posedge clk); #1;
    chk("busy_after", busy, 1'b0);
    chk("valid_after", valid, 1'b0);
    chk("pos_after", position, ep);
    prev_pos = ep;
    prev_err = ee;
    if (poke) begin
      for (int n = 0; n < 3; n++) begin
        @(posedge clk); #1;
        chk("poke_ignored_busy", busy, 1'b0);
        chk("poke_ignored_valid", valid, 1'b0);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    prev_pos = 3'b111;
    prev_err = 1'b0;
    set_rot(0);
`ifdef SEG_WORD_READER_AUTOSCAN_EN
    begin
      int cnt;
      set_rot(3);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_pos", position, 3'b111);
      rst_n = 1'b1;
      for (int v = 0; v < 5; v++) begin
        if (v == 3) set_rot(4);
        cnt = 0;
        do begin
          @(posedge clk); #1;
          cnt++;
        end while (!valid && cnt < 20);
        chk("auto_valid_seen", valid, 1'b1);
        if (v > 0) chk("auto_interval", 8'(cnt), 8'd8);
        chk("auto_busy", busy, 1'b1);
        if (v < 3) chk("auto_pos3", position, 3'd3);
        if (v == 4) chk("auto_pos4", position, 3'd4);
        chk("auto_err", error, 1'b0);
      end
    end
`else
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_pos", position, 3'b111);
    chk("rst_err", error, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", busy, 1'b0);

    // Every legal rotation
    set_rot(0); run_pass(0, 0);
    set_rot(5); run_pass(0, 0);
    for (int p = 1; p <= 4; p++) begin
      set_rot(p);
      run_pass(0, 0);
    end

    // Illegal pattern on one digit
    set_rot(0);
    hex[2] = 7'b0000000;
    run_pass(0, 0);
    chk("bad_digit_err", prev_err, 1'b1);

    // Legal letters, wrong order, with an ignored mid-pass start
    hex[0] = P_A; hex[1] = P_O; hex[2] = P_T;
    hex[3] = P_U; hex[4] = P_SP; hex[5] = P_SP;
    run_pass(0, 1);

    // Reset in the middle of a pass
    set_rot(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_pos", position, 3'b111);
    chk("midrst_err", error, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", valid, 1'b0);
    end
    rst_n = 1'b1;
    prev_pos = 3'b111;
    prev_err = 1'b0;
    set_rot(2);
    run_pass(0, 0);

    // start held high: a new pass from every IDLE cycle
    begin
      int nv;
      set_rot(4);
      nv = 0;
      start = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= 18; n++) begin
        @(posedge clk); #1;
        if (valid) nv++;
      end
      start = 1'b0;
      chk("held_start_valids", 8'(nv), 8'd2);
      chk("held_start_pos", position, 3'd4);
      nv = 0;
      while (busy && nv < 12) begin
        @(posedge clk); #1;
        nv++;
      end
      chk("held_start_drain", busy, 1'b0);
      prev_pos = 3'd4;
      prev_err = 1'b0;
    end

    // Randomized passes: corrupted digits, swaps, mid-scan changes
    for (int i = 0; i < 12; i++) begin
      int p, m, a, b;
      logic [0:6] t;
      p = $urandom_range(0, 5);
      m = $urandom_range(0, 3);
      set_rot(p);
      if (m == 1) hex[$urandom_range(0, 5)] = 7'($urandom);
      if (m == 2) begin
        a = $urandom_range(0, 5);
        b = $urandom_range(0, 5);
        t = hex[a]; hex[a] = hex[b]; hex[b] = t;
      end
      run_pass(m == 3, 0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_word_reader.md
SEG_WORD_READER -- requirements
Module: seg_word_reader

Interface
REQ-001 SHALL have port CLOCK_50  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports HEX0..HEX5  input  7 each, [0:6]  segment buses to be decoded, active-low, bit 0 = segment a.
REQ-004 SHALL have port start  input  1  request one decode pass, sampled in IDLE only.
REQ-005 SHALL have port busy  output  1  high while a pass is in progress.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when a result is published.
REQ-007 SHALL have port position  output  3  decoded rotation offset of the word, 0..5; 3'b111 when unknown.
REQ-008 SHALL have port error  output  1  high with valid when the pass produced no legal rotation; held until next result.

Function
REQ-009 SHALL decode each 7-bit pattern to a 3-bit char code: 1111111 -> SPACE(0), 0000010 -> A(1), 1100011 -> U(2), 1110000 -> T(3), 1100010 -> O(4), anything else -> BAD(7).
REQ-010 SHALL define the reference word W[0..5] = O,T,U,A,SPACE,SPACE; rotation p is legal when HEX((p+k) mod 6) decodes to W[k] for all k = 0..5.
REQ-011 SHALL implement FSM IDLE -> SCAN -> MATCH -> DONE -> IDLE.
REQ-012 IDLE: busy=0; start=1 at an edge -> SCAN with digit index 0 and busy=1 from that edge.
REQ-013 SCAN: one digit per clock, index 0..5, registering code of HEXindex; after index 5 -> MATCH (6 cycles in SCAN).
REQ-014 MATCH: compare stored codes against all six rotations in parallel in one cycle -> DONE.
REQ-015 DONE: register position/error, valid=1 for exactly this cycle, busy=0 next cycle, -> IDLE.
REQ-016 Latency: valid SHALL be high in the 8th cycle after the edge that accepted start.
REQ-017 Any BAD code or zero matching rotations SHALL give error=1, position=3'b111.
REQ-018 Exactly one matching rotation SHALL give error=0, position=p (the word has no rotational symmetry, so multiple matches cannot occur).
REQ-019 start while busy SHALL be ignored, not queued; start held high continuously SHALL start a new pass from each IDLE cycle.
REQ-020 HEX inputs changing mid-SCAN SHALL NOT abort the pass; the result reflects the per-cycle samples.
REQ-021 position and error SHALL hold their last published values between passes.

Reset
REQ-022 RESET_N low SHALL force, asynchronously: state IDLE, index 0, stored codes SPACE, busy=0, valid=0, error=0, position=3'b111.
REQ-023 Reset asserted mid-pass SHALL discard the pass and publish no valid pulse.

Configuration
REQ-024 Macro SEG_WORD_READER_AUTOSCAN_EN: when defined, DONE SHALL go directly to SCAN (index 0) and start SHALL be ignored. Passes run back-to-back, valid pulses every 8 cycles, and busy stays 1 after the first pass. The first pass begins in the first cycle after reset release.
REQ-025 When SEG_WORD_READER_AUTOSCAN_EN is undefined, behaviour SHALL be exactly REQ-011..REQ-021.

Structure
REQ-026 A shared package SHALL hold the char-code constants (SPACE, A, U, T, O, BAD), their 7-bit segment patterns, the word length 6 and the W[] order, shared with the display-side blocks.
REQ-027 Pattern-to-code decode SHALL be one combinational sub-module, seg7_char_decode, instantiated once on the index-muxed HEX bus.

Verification
REQ-028 HEX0..5 = o,t,u,a,sp,sp; pulse start -> 8th cycle valid=1, position=0, error=0; busy high for cycles 0..7.
REQ-029 HEX0..5 = t,u,a,sp,sp,o (rotation 5) -> position=5, error=0; repeat for rotations 1..4 -> position 1..4.
REQ-030 HEX2 = 0000000, rest as rotation 0 -> valid with error=1, position=3'b111.
REQ-031 All six digits legal but out of order (a,o,t,u,sp,sp) -> error=1, position=3'b111; start pulsed at cycle 3 of the pass is ignored (a single valid).
REQ-032 RESET_N low at cycle 4 of a pass -> outputs at reset values immediately, no valid. After release and a new start with rotation 2 -> position=2.
REQ-033 With SEG_WORD_READER_AUTOSCAN_EN, rotation 3 static -> valid every 8 cycles with position=3. Switching to rotation 4 -> position=4 by the second valid after the change.
